// File: rtl/output_buffer_ctrl_if.sv
// Control bundle between the layer sequencer and the output buffer controller:
// pass requests and MAC strobes in, buffer strobes and status out.
interface output_buffer_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] CS;
    logic [9:0] acc_len;
    logic       result_33_vld;
    logic       output_buffer_initial;
    logic       en;
    logic       store_en;
    logic       sum_en;
    logic [4:0] init_times;
    logic [3:0] cs_o;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, CS, acc_len, result_33_vld,
        input  output_buffer_initial, en, store_en, sum_en, init_times, cs_o, busy, done
    );

    modport slave (
        input  start, abort, CS, acc_len, result_33_vld,
        output output_buffer_initial, en, store_en, sum_en, init_times, cs_o, busy, done
    );
endinterface

// File: rtl/output_buffer_ctrl.sv
// Sequences one output-buffer pass per start: bias init, a settling gap,
// accumulation over the MAC result beats, optional FC sum-down, then done.
module output_buffer_ctrl #(
    parameter int         FC_INIT_BEATS = 28,
    parameter int         SUM_BEATS     = 11,
    parameter logic [3:0] SCONV_1       = 4'h1,
    parameter logic [3:0] SCONV_2       = 4'h2,
    parameter logic [3:0] SFC_1         = 4'h4,
    parameter logic [3:0] SFC_2         = 4'h8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output_buffer_ctrl_if.slave        bus
);
    localparam int SW = $clog2(SUM_BEATS + 1);

    typedef enum logic [2:0] {IDLE, INIT, GAP, ACC, SUM, DONE} state_t;

    state_t        state, state_n;
    logic [4:0]    init_cnt, init_n;
    logic [9:0]    beat_cnt, beat_n;
    logic [SW-1:0] sum_cnt, sum_n;
    logic [9:0]    len_q, len_n;
    logic [3:0]    cs_n;
    logic          fc_q, fc_n;
    logic          legal, is_fc;

    assign is_fc = (bus.CS == SFC_1) || (bus.CS == SFC_2);
    assign legal = is_fc || (bus.CS == SCONV_1) || (bus.CS == SCONV_2);

    always_comb begin
        state_n = state;
        init_n  = init_cnt;
        beat_n  = beat_cnt;
        sum_n   = sum_cnt;
        len_n   = len_q;
        cs_n    = bus.cs_o;
        fc_n    = fc_q;
        case (state)
            IDLE: begin
                if (bus.start && legal) begin
                    state_n = INIT;
                    cs_n    = bus.CS;
                    len_n   = bus.acc_len;
                    fc_n    = is_fc;
                    init_n  = '0;
                end
            end
            INIT: begin
                if (fc_q && (init_cnt != 5'(FC_INIT_BEATS - 1))) begin
                    init_n = init_cnt + 5'd1;
                end else begin
                    init_n  = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                beat_n = '0;
                sum_n  = '0;
                if (len_q != 10'd0) state_n = ACC;
                else if (fc_q)      state_n = SUM;
                else                state_n = DONE;
            end
            ACC: begin
                if (bus.result_33_vld) begin
                    if (beat_cnt == len_q - 10'd1) begin
                        beat_n  = '0;
                        state_n = fc_q ? SUM : DONE;
                    end else begin
                        beat_n = beat_cnt + 10'd1;
                    end
                end
            end
            SUM: begin
                if (sum_cnt == SW'(SUM_BEATS - 1)) begin
                    sum_n   = '0;
                    state_n = DONE;
                end else begin
                    sum_n = sum_cnt + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort overrides whatever the pass was about to do
        if (bus.abort && (state != IDLE)) begin
            state_n = IDLE;
            init_n  = '0;
            beat_n  = '0;
            sum_n   = '0;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            init_cnt                  <= '0;
            beat_cnt                  <= '0;
            sum_cnt                   <= '0;
            len_q                     <= '0;
            fc_q                      <= 1'b0;
            bus.cs_o                  <= '0;
            bus.init_times            <= '0;
            bus.output_buffer_initial <= 1'b0;
            bus.en                    <= 1'b0;
            bus.store_en              <= 1'b0;
            bus.sum_en                <= 1'b0;
            bus.busy                  <= 1'b0;
            bus.done                  <= 1'b0;
        end else begin
            state                     <= state_n;
            init_cnt                  <= init_n;
            beat_cnt                  <= beat_n;
            sum_cnt                   <= sum_n;
            len_q                     <= len_n;
            fc_q                      <= fc_n;
            bus.cs_o                  <= cs_n;
            bus.init_times            <= (state_n == INIT) ? init_n : 5'd0;
            bus.output_buffer_initial <= (state_n == INIT);
            bus.en                    <= (state_n == ACC);
            bus.store_en              <= (state_n == ACC) && !fc_n && (beat_n == len_n - 10'd1);
            bus.sum_en                <= (state_n == SUM);
            bus.busy                  <= (state_n != IDLE);
            bus.done                  <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Randomised and directed bench for output_buffer_ctrl: a queue-based pass
// planner predicts every output each cycle; directed passes pin literal counts.
module tb_output_buffer_ctrl;
    localparam logic [3:0] C1 = 4'h1;
    localparam logic [3:0] C2 = 4'h2;
    localparam logic [3:0] F1 = 4'h4;
    localparam logic [3:0] F2 = 4'h8;
    localparam int NINIT = 28;
    localparam int NSUM  = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_buffer_ctrl_if bus();

    output_buffer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       init;
        logic [4:0] times;
        logic       en;
        logic       store;
        logic       sum;
        logic       busy;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_E = '{init:1'b0, times:5'd0, en:1'b0, store:1'b0, sum:1'b0, busy:1'b0, done:1'b0};

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_o = IDLE_E;
    exp_t q[$];
    logic [3:0] m_cs = 4'd0;
    int   m_len = 0;
    bit   m_fc = 0;
    bit   in_acc = 0;
    int   beats = 0;

    int cnt_init, cnt_en, cnt_store, cnt_sum, cnt_done, max_times, en_idx, store_pos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t busy_e();
        exp_t e = IDLE_E;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic push_tail();
        exp_t e;
        if (m_fc) begin
            for (int i = 0; i < NSUM; i++) begin
                e = busy_e(); e.sum = 1'b1; q.push_back(e);
            end
        end
        e = busy_e(); e.done = 1'b1; q.push_back(e);
    endtask

    task automatic pop_next();
        exp_o = q.pop_front();
        if (exp_o.en) begin
            in_acc = 1; beats = 0;
            exp_o.store = !m_fc && (m_len == 1);
        end
    endtask

    // Reference model: a planned pass is a queue of per-cycle outputs; ACC is resolved beat by beat
    initial forever begin
        exp_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); in_acc = 0; beats = 0; exp_o = IDLE_E; m_cs = 4'd0;
        end else if (exp_o.busy && bus.abort) begin
            q.delete(); in_acc = 0; exp_o = IDLE_E;
        end else if (in_acc) begin
            if (bus.result_33_vld) beats++;
            if (beats == m_len) begin
                in_acc = 0;
                push_tail();
                pop_next();
            end else begin
                exp_o = busy_e(); exp_o.en = 1'b1;
                exp_o.store = !m_fc && (beats == m_len - 1);
            end
        end else if (q.size() > 0) begin
            pop_next();
        end else if (exp_o.busy) begin
            exp_o = IDLE_E;
        end else if (bus.start && (bus.CS == C1 || bus.CS == C2 || bus.CS == F1 || bus.CS == F2)) begin
            m_cs  = bus.CS;
            m_len = int'(bus.acc_len);
            m_fc  = (bus.CS == F1 || bus.CS == F2);
            for (int i = 0; i < (m_fc ? NINIT : 1); i++) begin
                e = busy_e(); e.init = 1'b1; e.times = 5'(i); q.push_back(e);
            end
            q.push_back(busy_e());
            if (m_len == 0) push_tail();
            else begin
                e = busy_e(); e.en = 1'b1; q.push_back(e);
            end
            pop_next();
        end
    end

    // Every-cycle comparison against the model, plus pass statistics for literal checks
    initial forever begin
        @(negedge clk);
        check("initial",    bus.output_buffer_initial, exp_o.init);
        check("init_times", bus.init_times, exp_o.times);
        check("en",         bus.en, exp_o.en);
        check("store_en",   bus.store_en, exp_o.store);
        check("sum_en",     bus.sum_en, exp_o.sum);
        check("busy",       bus.busy, exp_o.busy);
        check("done",       bus.done, exp_o.done);
        check("cs_o",       bus.cs_o, m_cs);
        if (bus.output_buffer_initial) cnt_init++;
        if (bus.en) en_idx++;
        if (bus.en) cnt_en++;
        if (bus.store_en) begin cnt_store++; store_pos = en_idx; end
        if (bus.sum_en) cnt_sum++;
        if (bus.done) cnt_done++;
        if (int'(bus.init_times) > max_times) max_times = int'(bus.init_times);
    end

    task automatic clear_counts();
        cnt_init = 0; cnt_en = 0; cnt_store = 0; cnt_sum = 0; cnt_done = 0;
        max_times = 0; en_idx = 0; store_pos = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] cs, input logic [9:0] len);
        @(negedge clk);
        bus.start = 1'b1; bus.CS = cs; bus.acc_len = len;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.done) begin seen = 1; break; end
            @(negedge clk);
        end
        check("done_timeout", seen, 1);
        @(negedge clk);
    endtask

    task automatic wait_for_en(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.en) begin seen = 1; break; end
            @(negedge clk);
        end
        check("en_timeout", seen, 1);
    endtask

    task automatic wait_for_sum(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.sum_en) begin seen = 1; break; end
            @(negedge clk);
        end
        check("sum_timeout", seen, 1);
    endtask

    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.CS = 4'h0; bus.acc_len = 10'd0; bus.result_33_vld = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_cs_o", bus.cs_o, 0);
        rst_n = 1'b1;

        // Conv pass, three beats back to back
        clear_counts();
        bus.result_33_vld = 1'b1;
        applyStimulus(C1, 10'd3);
        wait_done(100);
        check("conv_init_cycles", cnt_init, 1);
        check("conv_en_cycles", cnt_en, 3);
        check("conv_store_count", cnt_store, 1);
        check("conv_store_pos", store_pos, 3);
        check("conv_sum_cycles", cnt_sum, 0);
        check("conv_done_count", cnt_done, 1);

        // FC pass with full bias load and sum-down
        clear_counts();
        applyStimulus(F1, 10'd2);
        wait_done(200);
        check("fc_init_cycles", cnt_init, 28);
        check("fc_max_times", max_times, 27);
        check("fc_en_cycles", cnt_en, 2);
        check("fc_sum_cycles", cnt_sum, 11);
        check("fc_store_count", cnt_store, 0);
        check("fc_done_count", cnt_done, 1);

        // Gapped beats stretch ACC
        clear_counts();
        bus.result_33_vld = 1'b0;
        applyStimulus(C1, 10'd3);
        wait_for_en(20);
        for (int i = 0; i < 5; i++) begin
            bus.result_33_vld = pat[i];
            @(negedge clk);
        end
        bus.result_33_vld = 1'b0;
        wait_done(20);
        check("gap_en_cycles", cnt_en, 5);
        check("gap_store_pos", store_pos, 5);

        // Abort in the fourth SUM cycle
        clear_counts();
        bus.result_33_vld = 1'b1;
        applyStimulus(F2, 10'd2);
        wait_for_sum(200);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_sum_en", bus.sum_en, 0);
        check("abort_busy", bus.busy, 0);
        repeat (15) @(negedge clk);
        check("abort_no_done", cnt_done, 0);
        check("abort_sum_cycles", cnt_sum, 4);
        clear_counts();
        applyStimulus(C2, 10'd2);
        wait_done(100);
        check("post_abort_done", cnt_done, 1);

        // Illegal code, then an empty conv pass
        applyStimulus(4'hF, 10'd3);
        check("illegal_busy", bus.busy, 0);
        @(negedge clk);
        check("illegal_busy2", bus.busy, 0);
        clear_counts();
        applyStimulus(C2, 10'd0);
        wait_done(100);
        check("empty_init_cycles", cnt_init, 1);
        check("empty_en_cycles", cnt_en, 0);
        check("empty_done_count", cnt_done, 1);

        // Asynchronous reset in the middle of an FC bias load
        applyStimulus(F1, 10'd1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_initial", bus.output_buffer_initial, 0);
        check("arst_init_times", bus.init_times, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_cs_o", bus.cs_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        bus.start = 1'b1; bus.CS = C1; bus.acc_len = 10'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("arst_restart_busy", bus.busy, 1);
        wait_done(100);
        check("arst_restart_done", cnt_done, 1);

        // Random traffic: starts at any time, sparse aborts, random beats
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 5))
                0: bus.CS = C1;
                1: bus.CS = C2;
                2: bus.CS = F1;
                3: bus.CS = F2;
                4: bus.CS = 4'(C1 + C2);
                default: bus.CS = 4'($urandom_range(0, 15));
            endcase
            bus.acc_len = 10'($urandom_range(0, 6));
            bus.result_33_vld = $urandom_range(0, 1) == 1;
            bus.abort = ($urandom_range(0, 60) == 0);
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/output_buffer_ctrl.md
OUTPUT_BUFFER_CTRL -- requirements
Module: output_buffer_ctrl

Interface
REQ-001 SHALL have parameter FC_INIT_BEATS, default 28, number of bias-load cycles for FC layers (4 biases per cycle, 112 lanes).
REQ-002 SHALL have parameter SUM_BEATS, default 11, number of sum_en cycles for the FC sum-down (280 bits per cycle).
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run one layer pass; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current pass.
REQ-007 SHALL have port CS  input  4  layer code (`SCONV_1, `SCONV_2, `SFC_1, `SFC_2 from def_header.vh); sampled with start.
REQ-008 SHALL have port acc_len  input  10  number of result_33_vld beats in the pass; sampled with start.
REQ-009 SHALL have port result_33_vld  input  1  MAC array result-valid strobe.
REQ-010 SHALL have ports output_buffer_initial, en, store_en, sum_en  output  1 each  output buffer control strobes.
REQ-011 SHALL have port init_times  output  5  FC bias-slice index.
REQ-012 SHALL have port cs_o  output  4  latched layer code driven to the output buffer CS input.
REQ-013 SHALL have ports busy, done  output  1 each  pass in progress; one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, GAP, ACC, SUM, DONE; all outputs registered.
REQ-015 SHALL, in IDLE, on start=1 with CS one of the four legal codes, latch CS into cs_o, latch acc_len, and go to INIT; start with an illegal CS SHALL be ignored, with the FSM staying in IDLE.
REQ-016 SHALL assert output_buffer_initial in every INIT cycle: 1 cycle for conv codes; FC_INIT_BEATS cycles for FC codes, with init_times = 0,1,...,FC_INIT_BEATS-1 on consecutive cycles.
REQ-017 SHALL insert exactly one GAP cycle after INIT, with all strobes 0, to cover the delayed buffer-1 initialisation.
REQ-018 SHALL go from GAP to ACC when the latched acc_len != 0; when acc_len == 0, SHALL go to SUM for FC codes and to DONE for conv codes.
REQ-019 SHALL hold en=1 for the whole of ACC and en=0 in every other state.
REQ-020 SHALL count result_33_vld beats in ACC with a 10-bit counter cleared on entry; vld outside ACC SHALL be ignored.
REQ-021 SHALL, for conv codes, hold store_en=1 while in ACC with beat count == acc_len-1, so that store_en coincides with the final beat.
REQ-022 SHALL leave ACC on the beat with count == acc_len-1 and vld=1: to SUM for FC codes, to DONE for conv codes.
REQ-023 SHALL assert sum_en for exactly SUM_BEATS consecutive cycles in SUM, then go to DONE.
REQ-024 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL, on abort=1 in any state other than IDLE, go to IDLE the next cycle with all strobes 0 and no done pulse; abort has priority over every other transition.
REQ-027 SHALL hold init_times at 0 outside INIT and SHALL never let it exceed FC_INIT_BEATS-1.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, all counters 0, and cs_o, init_times, output_buffer_initial, en, store_en, sum_en, busy and done to 0, asynchronously.
REQ-029 SHALL, when rst_n is deasserted mid-pass, resume in IDLE and accept a new start from the first clock edge after release.

Verification
REQ-030 SHALL be verified with the following scenario: start, CS=`SCONV_1, acc_len=3, vld every cycle -> initial 1 cycle, 1 GAP cycle, en 3 cycles, store_en on the 3rd beat only, no sum_en, done 1 cycle later.
REQ-031 SHALL be verified with the following scenario: start, CS=`SFC_1, acc_len=2 -> 28 init cycles with init_times 0..27, GAP, ACC, sum_en exactly 11 cycles, then done; store_en never asserted.
REQ-032 SHALL be verified with the following scenario: ACC with vld gapped (1,0,0,1,1) and acc_len=3 -> en held for 5 cycles, exit on the 5th cycle.
REQ-033 SHALL be verified with the following scenario: abort during SUM (cycle 4) -> sum_en 0 next cycle, busy 0, done never pulsed; a subsequent start runs normally.
REQ-034 SHALL be verified with the following scenario: start with CS=4'hF -> busy stays 0; start with acc_len=0 and CS=`SCONV_2 -> INIT, GAP, DONE, with no en.
REQ-035 SHALL be verified with the following scenario: rst_n pulsed low during INIT of an FC pass -> all outputs 0 immediately, before any clock edge; after release, IDLE.
